filter_median3x3: RTL and testbench
===================================

# filter_median3x3

Pipelined 3x3 median filter for the image-processing datapath. Each accepted 3x3 window of unsigned pixels yields the median (5th smallest of 9) a fixed three cycles later. It sits after the line-buffer/window generator and before downstream pixel consumers. No back-pressure; throughput is one window per clock.

## Interface
- `PixelBit`, default 8: width of one unsigned pixel.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `in_valid` input, 1: `window` holds a valid window this cycle.
- `window` input, `PixelBit*9`: nine packed pixels. P0 is the MSB slice `[PixelBit*9-1 -: PixelBit]` (top-left), then P1…P8 toward the LSB. Row r is P(3r)..P(3r+2).
- `out_valid` output, 1: `median` is valid this cycle.
- `median` output, `PixelBit`: median of the window accepted three cycles earlier.

## Operation
- Pixels are compared as unsigned; duplicates are allowed.
- Result equals element index 4 of the ascending sort of P0..P8.
- Stage 1 (row sort): each row is sorted into (lo, mid, hi) with a 3-input compare-swap network. Nine sorted values and the valid bit are registered.
- Stage 2 (column reduce):
  - maxlo = max of the three row lo values.
  - medmid = median of the three row mid values.
  - minhi = min of the three row hi values.
  - All three plus valid are registered.
- Stage 3: `median` = median(maxlo, medmid, minhi); registered together with `out_valid`.
- Every comparison is exactly `PixelBit` wide. No arithmetic widening, no rounding.
- Compare-swap tie rule: when values are equal, either ordering is acceptable, because the output value is identical.
- The valid bit travels alongside the data through all three stages.
- Data registers also update when `in_valid`=0. `median` is don't-care when `out_valid`=0, but must be deterministic.

## Timing
- Latency: exactly 3 clk edges from a sample of `window`/`in_valid` to the matching `median`/`out_valid`.
- Throughput: 1 window per cycle. Back-to-back windows produce back-to-back results with no bubbles.
- Reset:
  - `rst_n` low clears all pipeline registers immediately, including `out_valid`=0 and `median`=0.
  - Windows in flight are discarded.
  - The first result can appear 3 edges after the first `in_valid`=1 sampled while `rst_n` is high.
- Reset deassertion is synchronised externally. The block takes no action on it beyond clearing.
- No combinational path from any input to any output.

## Structure
- A shared package holds:
  - the default pixel width constant.
  - the window slice helper: index of pixel k = `PixelBit*(8-k)`.
- One natural sub-module, `median_sort3`:
  - combinational; three `PixelBit` inputs in, lo/mid/hi out.
  - three compare-swaps.
- Use it three times in stage 1. Reuse its mid output for the medmid and final-median computations.
- Stage-2 max/min are plain comparators.

## Test plan
- Ordered window {1,2,3,4,5,6,7,8,9} (P0=1), `in_valid`=1 for one cycle -> `out_valid`=1 exactly 3 cycles later, `median`=5. `out_valid`=0 on every other cycle.
- Duplicates {2,2,3,1,3,1,4,2,4} -> `median`=2 after 3 cycles.
- Reversed window {9,8,7,6,5,4,3,2,1} and all-equal 8'hAA window -> 5 and 8'hAA respectively.
- Extremes {0,255,0,255,0,255,0,255,128} -> 128. All-zero window -> 0. All-ones window -> 255.
- Streaming: 1000 back-to-back random windows with `in_valid` toggled randomly -> each `median` matches a software sort at index 4. `out_valid` pattern equals the `in_valid` pattern delayed by 3.
- Reset mid-stream: assert `rst_n`=0 while 2 windows are in flight -> `out_valid` and `median` go to 0 immediately with no clock edge needed, and no stale result emerges after release.

Source files
------------

// File: rtl/filter_median3x3_pkg.sv
// filter_median3x3_pkg: shared pixel width and window slice helper
package filter_median3x3_pkg;
  localparam int PixelBitDef = 8;
  function automatic int pix_lsb(input int pixel_bit, input int k);
    return pixel_bit * (8 - k);
  endfunction
endpackage

// File: rtl/filter_median3x3_sort3.sv
// median_sort3: combinational three-input sorter built from three compare-swaps
module median_sort3 #(
  parameter int PixelBit = 8
) (
  input  logic [PixelBit-1:0] a,
  input  logic [PixelBit-1:0] b,
  input  logic [PixelBit-1:0] c,
  output logic [PixelBit-1:0] lo,
  output logic [PixelBit-1:0] mid,
  output logic [PixelBit-1:0] hi
);
  logic [PixelBit-1:0] x0, x1, y1;
  always_comb begin
    x0  = a < b ? a : b;
    x1  = a < b ? b : a;
    y1  = x1 < c ? x1 : c;
    hi  = x1 < c ? c : x1;
    lo  = x0 < y1 ? x0 : y1;
    mid = x0 < y1 ? y1 : x0;
  end
endmodule

// File: rtl/filter_median3x3.sv
// filter_median3x3: three-stage pipelined 3x3 median (row sort, column reduce, final median)
module filter_median3x3
  import filter_median3x3_pkg::*;
#(
  parameter int PixelBit = PixelBitDef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [PixelBit*9-1:0] window,
  output logic                  out_valid,
  output logic [PixelBit-1:0]   median
);
  logic [2:0][PixelBit-1:0] r_lo, r_mid, r_hi, s1_lo, s1_mid, s1_hi;
  logic                     s1_v, s2_v;
  logic [PixelBit-1:0]      s2_maxlo, s2_medmid, s2_minhi;
  logic [PixelBit-1:0]      lo01, hi01, maxlo, minhi, medmid, med;
  logic [PixelBit-1:0]      unused_lo_a, unused_hi_a, unused_lo_b, unused_hi_b;
  for (genvar r = 0; r < 3; r++) begin : g_row
    median_sort3 #(.PixelBit(PixelBit)) u_row (
      .a  (window[pix_lsb(PixelBit, 3*r)   +: PixelBit]),
      .b  (window[pix_lsb(PixelBit, 3*r+1) +: PixelBit]),
      .c  (window[pix_lsb(PixelBit, 3*r+2) +: PixelBit]),
      .lo (r_lo[r]),
      .mid(r_mid[r]),
      .hi (r_hi[r])
    );
  end
  always_comb begin
    lo01  = s1_lo[0] > s1_lo[1] ? s1_lo[0] : s1_lo[1];
    maxlo = lo01 > s1_lo[2] ? lo01 : s1_lo[2];
    hi01  = s1_hi[0] < s1_hi[1] ? s1_hi[0] : s1_hi[1];
    minhi = hi01 < s1_hi[2] ? hi01 : s1_hi[2];
  end
  median_sort3 #(.PixelBit(PixelBit)) u_medmid (
    .a(s1_mid[0]), .b(s1_mid[1]), .c(s1_mid[2]),
    .lo(unused_lo_a), .mid(medmid), .hi(unused_hi_a)
  );
  median_sort3 #(.PixelBit(PixelBit)) u_final (
    .a(s2_maxlo), .b(s2_medmid), .c(s2_minhi),
    .lo(unused_lo_b), .mid(med), .hi(unused_hi_b)
  );
  // Data registers load every cycle; only the valid bit marks meaningful results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_lo     <= '0;
      s1_mid    <= '0;
      s1_hi     <= '0;
      s2_v      <= 1'b0;
      s2_maxlo  <= '0;
      s2_medmid <= '0;
      s2_minhi  <= '0;
      out_valid <= 1'b0;
      median    <= '0;
    end else begin
      s1_v      <= in_valid;
      s1_lo     <= r_lo;
      s1_mid    <= r_mid;
      s1_hi     <= r_hi;
      s2_v      <= s1_v;
      s2_maxlo  <= maxlo;
      s2_medmid <= medmid;
      s2_minhi  <= minhi;
      out_valid <= s2_v;
      median    <= med;
    end
  end
endmodule

// File: tb/tb_filter_median3x3.sv
// tb_filter_median3x3: random and directed windows checked against a counting-rank median model
module tb_filter_median3x3;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [71:0] window = '0;
  logic        out_valid;
  logic [7:0]  median;
  int          vecs = 0;
  int          errs = 0;
  bit          qv[$];
  logic [7:0]  qm[$];

  filter_median3x3 #(.PixelBit(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .window   (window),
    .out_valid(out_valid),
    .median   (median)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] pack9(input int p[9]);
    logic [71:0] w = '0;
    for (int k = 0; k < 9; k++) w[8*(8-k) +: 8] = p[k][7:0];
    return w;
  endfunction

  // Median is the value whose rank range in the multiset covers position 4.
  function automatic logic [7:0] ref_med(input logic [71:0] w);
    logic [7:0] px[9];
    for (int k = 0; k < 9; k++) px[k] = w[8*(8-k) +: 8];
    for (int i = 0; i < 9; i++) begin
      int lt = 0, le = 0;
      for (int j = 0; j < 9; j++) begin
        if (px[j] < px[i]) lt++;
        if (px[j] <= px[i]) le++;
      end
      if (lt <= 4 && le >= 5) return px[i];
    end
    return 8'h00;
  endfunction

  task automatic model_reset();
    qv = {1'b0, 1'b0};
    qm = {8'h00, 8'h00};
  endtask

  task automatic cycle(input bit v, input logic [71:0] w, input string tag);
    @(negedge clk);
    in_valid = v;
    window   = w;
    @(posedge clk);
    #1;
    qv.push_back(v);
    qm.push_back(ref_med(w));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(qv[0]));
    if (qv[0]) chk({tag, ".median"}, 32'(median), 32'(qm[0]));
    void'(qv.pop_front());
    void'(qm.pop_front());
  endtask

  task automatic directed(input int p[9], input string tag);
    logic [71:0] w;
    w = pack9(p);
    cycle(1'b1, w, tag);
    for (int i = 0; i < 3; i++) cycle(1'b0, {$urandom(), $urandom(), $urandom()}, tag);
  endtask

  initial begin
    int p[9];
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.median", 32'(median), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    p = '{1, 2, 3, 4, 5, 6, 7, 8, 9};               directed(p, "ordered");
    p = '{2, 2, 3, 1, 3, 1, 4, 2, 4};               directed(p, "dups");
    p = '{9, 8, 7, 6, 5, 4, 3, 2, 1};               directed(p, "reversed");
    p = '{170, 170, 170, 170, 170, 170, 170, 170, 170}; directed(p, "all_aa");
    p = '{0, 255, 0, 255, 0, 255, 0, 255, 128};     directed(p, "extremes");
    p = '{0, 0, 0, 0, 0, 0, 0, 0, 0};               directed(p, "zeros");
    p = '{255, 255, 255, 255, 255, 255, 255, 255, 255}; directed(p, "ones");
    for (int n = 0; n < 1000; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? 7 : 255;
      for (int k = 0; k < 9; k++) p[k] = int'($urandom_range(0, lim));
      cycle(1'($urandom_range(0, 1)), pack9(p), "stream");
    end
    for (int n = 0; n < 3; n++) begin
      p = '{9, 9, 9, 9, 9, 9, 9, 9, 9};
      cycle(1'b1, pack9(p), "preflight");
    end
    chk("preflight.median_nonzero", 32'(median), 32'd9);
    p = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
    @(negedge clk);
    in_valid = 1'b1;
    window   = pack9(p);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 32'(out_valid), 32'd0);
    chk("async_rst.median", 32'(median), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 5; n++) cycle(1'b0, pack9(p), "post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
